// File: rtl/calc_controller_pkg.sv
// Shared encodings for the keypad calculator controller: FSM states, key
// types, ALU op codes and the operand limit.
package calc_controller_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'b00,
        KEY_OP    = 2'b01,
        KEY_EQ    = 2'b10,
        KEY_CLR   = 2'b11
    } key_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_BAD = 2'b11
    } op_e;

    localparam logic [11:0] OPERAND_MAX = 12'd255;

endpackage

// File: rtl/calc_controller_bcd_accum.sv
// Decimal digit accumulator: value*10+digit at 12 bits, flagging bad digits,
// too many digits, or a result above the operand limit.
module bcd_accum
    import calc_controller_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned CNT_W      = 2
) (
    input  logic [7:0]       cur_val,
    input  logic [CNT_W-1:0] cur_cnt,
    input  logic [3:0]       digit,
    output logic [7:0]       new_val,
    output logic [CNT_W-1:0] new_cnt,
    output logic             overflow
);

    logic [11:0]    wide_val;
    logic [CNT_W:0] cnt_next;

    always_comb begin
        wide_val = ({4'b0000, cur_val} * 12'd10) + {8'h00, digit};
        cnt_next = {1'b0, cur_cnt} + {{CNT_W{1'b0}}, 1'b1};
        overflow = (digit > 4'd9) || (32'(cnt_next) > MAX_DIGITS) || (wide_val > OPERAND_MAX);
        new_val  = wide_val[7:0];
        new_cnt  = cnt_next[CNT_W-1:0];
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad calculator controller: collects two decimal operands and one op,
// drives an external ALU and registers its result for display.
module calc_controller
    import calc_controller_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        KEY_VALID,
    input  logic [1:0]  KEY_TYPE,
    input  logic [3:0]  KEY_VAL,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [1:0]  ALU_OP,
    input  logic [15:0] ALU_RESULT,
    input  logic        ALU_NEG,
    output logic [15:0] DISP_VALUE,
    output logic        DISP_NEG,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int unsigned CNT_W = (MAX_DIGITS < 2) ? 1 : $clog2(MAX_DIGITS + 1);

    state_e            state_q, state_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [15:0]       disp_value_q, disp_value_d;
    logic              disp_neg_q, disp_neg_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [7:0]        acc_cur_val, acc_new_val;
    logic [CNT_W-1:0]  acc_cur_cnt, acc_new_cnt;
    logic              acc_ovf;
    key_e              key_type;
    op_e               key_op;
    logic              chain_ok;

    // One accumulator shared by A and B; SHOW starts a fresh operand from zero.
    always_comb begin
        acc_cur_val = a_q;
        acc_cur_cnt = cnt_a_q;
        if (state_q == ST_ENTER_B) begin
            acc_cur_val = b_q;
            acc_cur_cnt = cnt_b_q;
        end else if (state_q == ST_SHOW) begin
            acc_cur_val = '0;
            acc_cur_cnt = '0;
        end
    end

    bcd_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_bcd_accum (
        .cur_val  (acc_cur_val),
        .cur_cnt  (acc_cur_cnt),
        .digit    (KEY_VAL),
        .new_val  (acc_new_val),
        .new_cnt  (acc_new_cnt),
        .overflow (acc_ovf)
    );

    always_comb begin
        key_type     = key_e'(KEY_TYPE);
        key_op       = op_e'(KEY_VAL[1:0]);
        chain_ok     = (ALU_RESULT <= {4'h0, OPERAND_MAX}) && !ALU_NEG;
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        disp_value_d = disp_value_q;
        disp_neg_d   = disp_neg_q;
        done_d       = 1'b0;

        if (KEY_VALID && key_type == KEY_CLR) begin
            state_d = ST_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            case (state_q)
                ST_ENTER_A, ST_ENTER_B: begin
                    if (KEY_VALID) begin
                        case (key_type)
                            KEY_DIGIT: begin
                                if (acc_ovf) begin
                                    state_d = ST_ERROR;
                                end else if (state_q == ST_ENTER_A) begin
                                    a_d     = acc_new_val;
                                    cnt_a_d = acc_new_cnt;
                                end else begin
                                    b_d     = acc_new_val;
                                    cnt_b_d = acc_new_cnt;
                                end
                            end
                            KEY_OP: begin
                                if (key_op == OP_BAD) begin
                                    state_d = ST_ERROR;
                                end else if (state_q == ST_ENTER_A) begin
                                    op_d    = key_op;
                                    b_d     = '0;
                                    cnt_b_d = '0;
                                    state_d = ST_ENTER_B;
                                end
                            end
                            KEY_EQ: begin
                                if (state_q == ST_ENTER_B) state_d = ST_EXEC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    disp_value_d = ALU_RESULT;
                    disp_neg_d   = ALU_NEG;
                    done_d       = 1'b1;
                    state_d      = ST_SHOW;
                end
                ST_SHOW: begin
                    if (KEY_VALID && key_type == KEY_DIGIT) begin
                        if (acc_ovf) begin
                            state_d = ST_ERROR;
                        end else begin
                            a_d     = acc_new_val;
                            cnt_a_d = acc_new_cnt;
                            state_d = ST_ENTER_A;
                        end
                    end else if (KEY_VALID && key_type == KEY_OP) begin
                        if (key_op == OP_BAD || !chain_ok) begin
                            state_d = ST_ERROR;
                        end else begin
                            a_d     = ALU_RESULT[7:0];
                            op_d    = key_op;
                            b_d     = '0;
                            cnt_b_d = '0;
                            state_d = ST_ENTER_B;
                        end
                    end
                end
                ST_ERROR: ;
                default: state_d = ST_ENTER_A;
            endcase
        end

        // Display follows the operand being edited; SHOW/EXEC/ERROR hold it.
        if (state_d == ST_ENTER_A) disp_value_d = {8'h00, a_d};
        if (state_d == ST_ENTER_B) disp_value_d = {8'h00, b_d};
        if (state_d != ST_SHOW)    disp_neg_d   = 1'b0;
        busy_d = (state_d == ST_EXEC);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_ENTER_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            disp_value_q <= '0;
            disp_neg_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            disp_value_q <= disp_value_d;
            disp_neg_q   <= disp_neg_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_OP     = op_q;
    assign DISP_VALUE = disp_value_q;
    assign DISP_NEG   = disp_neg_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: directed key tables, a DONE latency sequence,
// and random keys checked against a behavioural calculator model.
module tb_calc_controller;

    localparam int MAXD = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        KEY_VALID = 1'b0;
    logic [1:0]  KEY_TYPE = 2'b00;
    logic [3:0]  KEY_VAL = 4'h0;
    logic [7:0]  ALU_A, ALU_B;
    logic [1:0]  ALU_OP;
    logic [15:0] ALU_RESULT;
    logic        ALU_NEG;
    logic [15:0] DISP_VALUE;
    logic        DISP_NEG, BUSY, DONE, ERR;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    calc_controller #(.MAX_DIGITS(MAXD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY_VALID  (KEY_VALID),
        .KEY_TYPE   (KEY_TYPE),
        .KEY_VAL    (KEY_VAL),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_OP     (ALU_OP),
        .ALU_RESULT (ALU_RESULT),
        .ALU_NEG    (ALU_NEG),
        .DISP_VALUE (DISP_VALUE),
        .DISP_NEG   (DISP_NEG),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    // External ALU stand-in.
    always_comb begin
        ALU_NEG = 1'b0;
        case (ALU_OP)
            2'b00: ALU_RESULT = 16'(ALU_A) + 16'(ALU_B);
            2'b01: begin
                ALU_RESULT = 16'(ALU_A) - 16'(ALU_B);
                ALU_NEG    = (ALU_A < ALU_B);
            end
            2'b10: ALU_RESULT = 16'(ALU_A) * 16'(ALU_B);
            default: ALU_RESULT = '0;
        endcase
    end

    // Behavioural model of the calculator as a user sees it.
    localparam int M_A = 0, M_B = 1, M_EXEC = 2, M_SHOW = 3, M_ERR = 4;
    int m_mode = M_A, m_a = 0, m_b = 0, m_op = 0, m_na = 0, m_nb = 0, m_disp = 0;
    bit m_neg = 0, m_done = 0;

    function automatic void alu_ref(input int a, input int b, input int op, output int res, output bit neg);
        neg = 0;
        case (op)
            0: res = a + b;
            1: begin res = (a - b) & 'hFFFF; neg = (a < b); end
            2: res = a * b;
            default: res = 0;
        endcase
    endfunction

    task automatic model_clear();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_na = 0; m_nb = 0;
        m_disp = 0; m_neg = 0; m_done = 0;
    endtask

    task automatic model_step(input bit rst, input bit kv, input int kt, input int kval);
        int res, cur, n, nv;
        bit neg;
        m_done = 0;
        if (rst || (kv && kt == 3)) begin
            model_clear();
        end else begin
            case (m_mode)
                M_A, M_B: if (kv) begin
                    if (kt == 0) begin
                        cur = (m_mode == M_A) ? m_a : m_b;
                        n   = (m_mode == M_A) ? m_na : m_nb;
                        nv  = cur * 10 + kval;
                        if (kval > 9 || n + 1 > MAXD || nv > 255) m_mode = M_ERR;
                        else if (m_mode == M_A) begin m_a = nv; m_na = n + 1; end
                        else begin m_b = nv; m_nb = n + 1; end
                    end else if (kt == 1) begin
                        if (kval % 4 == 3) m_mode = M_ERR;
                        else if (m_mode == M_A) begin
                            m_op = kval % 4; m_b = 0; m_nb = 0; m_mode = M_B;
                        end
                    end else if (kt == 2 && m_mode == M_B) begin
                        m_mode = M_EXEC;
                    end
                end
                M_EXEC: begin
                    alu_ref(m_a, m_b, m_op, res, neg);
                    m_disp = res; m_neg = neg; m_done = 1; m_mode = M_SHOW;
                end
                M_SHOW: if (kv) begin
                    if (kt == 0) begin
                        if (kval > 9) m_mode = M_ERR;
                        else begin m_a = kval; m_na = 1; m_mode = M_A; end
                    end else if (kt == 1) begin
                        alu_ref(m_a, m_b, m_op, res, neg);
                        if (kval % 4 == 3 || res > 255 || neg) m_mode = M_ERR;
                        else begin
                            m_a = res; m_op = kval % 4; m_b = 0; m_nb = 0; m_mode = M_B;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (m_mode == M_A) m_disp = m_a;
        if (m_mode == M_B) m_disp = m_b;
        if (m_mode != M_SHOW) m_neg = 0;
    endtask

    // One clock: drive at negedge, step model at posedge, leave at next negedge.
    task automatic drive(input bit rst, input bit kv, input logic [1:0] kt, input logic [3:0] kval);
        RST = rst; KEY_VALID = kv; KEY_TYPE = kt; KEY_VAL = kval;
        @(posedge CLK);
        model_step(rst, kv, int'(kt), int'(kval));
        @(negedge CLK);
        RST = 1'b0; KEY_VALID = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [38:0] exp_v, got_v;
        exp_v = {8'(m_a), 8'(m_b), 2'(m_op), 16'(m_disp), m_neg,
                 (m_mode == M_EXEC), m_done, (m_mode == M_ERR)};
        got_v = {ALU_A, ALU_B, ALU_OP, DISP_VALUE, DISP_NEG, BUSY, DONE, ERR};
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got a=%0d b=%0d op=%0d disp=%0d neg=%0b busy=%0b done=%0b err=%0b, expected a=%0d b=%0d op=%0d disp=%0d neg=%0b busy=%0b done=%0b err=%0b",
                     tag, ALU_A, ALU_B, ALU_OP, DISP_VALUE, DISP_NEG, BUSY, DONE, ERR,
                     m_a, m_b, m_op, m_disp, m_neg, (m_mode == M_EXEC), m_done, (m_mode == M_ERR));
        end
    endtask

    typedef struct {
        bit          rst;
        bit          kv;
        logic [1:0]  kt;
        logic [3:0]  kval;
        logic [15:0] disp;
        bit          neg;
        bit          done;
        bit          err;
        bit          busy;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit kv, input logic [1:0] kt, input logic [3:0] kval,
                                input logic [15:0] disp, input bit neg, input bit done, input bit err,
                                input bit busy, input string name);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kt = kt; v.kval = kval; v.disp = disp;
        v.neg = neg; v.done = done; v.err = err; v.busy = busy; v.name = name;
        vecs.push_back(v);
    endfunction

    // Shorthands: key rows (type,val) and idle rows, with expected disp/neg/done/err/busy.
    function automatic void k(input logic [1:0] kt, input logic [3:0] kval, input logic [15:0] disp,
                              input bit neg, input bit done, input bit err, input bit busy, input string name);
        add(1'b0, 1'b1, kt, kval, disp, neg, done, err, busy, name);
    endfunction

    function automatic void idle(input logic [15:0] disp, input bit neg, input bit done, input bit err,
                                 input bit busy, input string name);
        add(1'b0, 1'b0, 2'b00, 4'h0, disp, neg, done, err, busy, name);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        @(negedge CLK);

        add(1'b1, 1'b0, 2'b00, 4'h0, 16'd0, 0, 0, 0, 0, "reset");
        // 123 + 45 = 168
        k(2'd0, 4'd1, 16'd1, 0, 0, 0, 0, "add_d1");
        k(2'd0, 4'd2, 16'd12, 0, 0, 0, 0, "add_d2");
        k(2'd0, 4'd3, 16'd123, 0, 0, 0, 0, "add_d3");
        k(2'd1, 4'd0, 16'd0, 0, 0, 0, 0, "add_op");
        k(2'd0, 4'd4, 16'd4, 0, 0, 0, 0, "add_d4");
        k(2'd0, 4'd5, 16'd45, 0, 0, 0, 0, "add_d5");
        k(2'd2, 4'd0, 16'd45, 0, 0, 0, 1, "add_exec");
        idle(16'd168, 0, 1, 0, 0, "add_done");
        idle(16'd168, 0, 0, 0, 0, "add_show");
        // 5 - 9 = -4
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "sub_clr");
        k(2'd0, 4'd5, 16'd5, 0, 0, 0, 0, "sub_d5");
        k(2'd1, 4'd1, 16'd0, 0, 0, 0, 0, "sub_op");
        k(2'd0, 4'd9, 16'd9, 0, 0, 0, 0, "sub_d9");
        k(2'd2, 4'd0, 16'd9, 0, 0, 0, 1, "sub_exec");
        idle(16'hFFFC, 1, 1, 0, 0, "sub_done");
        idle(16'hFFFC, 1, 0, 0, 0, "sub_show");
        // 255 * 255, then chain overflow
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "mul_clr");
        k(2'd0, 4'd2, 16'd2, 0, 0, 0, 0, "mul_a2");
        k(2'd0, 4'd5, 16'd25, 0, 0, 0, 0, "mul_a5");
        k(2'd0, 4'd5, 16'd255, 0, 0, 0, 0, "mul_a5b");
        k(2'd1, 4'd2, 16'd0, 0, 0, 0, 0, "mul_op");
        k(2'd0, 4'd2, 16'd2, 0, 0, 0, 0, "mul_b2");
        k(2'd0, 4'd5, 16'd25, 0, 0, 0, 0, "mul_b5");
        k(2'd0, 4'd5, 16'd255, 0, 0, 0, 0, "mul_b5b");
        k(2'd2, 4'd0, 16'd255, 0, 0, 0, 1, "mul_exec");
        idle(16'd65025, 0, 1, 0, 0, "mul_done");
        k(2'd1, 4'd2, 16'd65025, 0, 0, 1, 0, "chain_ovf");
        k(2'd0, 4'd2, 16'd65025, 0, 0, 1, 0, "err_ignores");
        // operand overflow and digit count
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "ovf_clr");
        k(2'd0, 4'd2, 16'd2, 0, 0, 0, 0, "ovf_d2");
        k(2'd0, 4'd5, 16'd25, 0, 0, 0, 0, "ovf_d5");
        k(2'd0, 4'd6, 16'd25, 0, 0, 1, 0, "ovf_256");
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "cnt_clr");
        k(2'd0, 4'd1, 16'd1, 0, 0, 0, 0, "cnt_d1");
        k(2'd0, 4'd2, 16'd12, 0, 0, 0, 0, "cnt_d2");
        k(2'd0, 4'd3, 16'd123, 0, 0, 0, 0, "cnt_d3");
        k(2'd0, 4'd4, 16'd123, 0, 0, 1, 0, "cnt_4th");
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "err_clr");
        k(2'd0, 4'd12, 16'd0, 0, 0, 1, 0, "digit_gt9");
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "gt9_clr");
        // reset during EXEC, clear priority, reset priority
        k(2'd0, 4'd1, 16'd1, 0, 0, 0, 0, "rx_d1");
        k(2'd1, 4'd0, 16'd0, 0, 0, 0, 0, "rx_op");
        k(2'd0, 4'd2, 16'd2, 0, 0, 0, 0, "rx_d2");
        k(2'd2, 4'd0, 16'd2, 0, 0, 0, 1, "rx_exec");
        add(1'b1, 1'b0, 2'b00, 4'h0, 16'd0, 0, 0, 0, 0, "rst_in_exec");
        idle(16'd0, 0, 0, 0, 0, "no_done");
        k(2'd0, 4'd4, 16'd4, 0, 0, 0, 0, "cp_d4");
        k(2'd3, 4'd7, 16'd0, 0, 0, 0, 0, "clr_wins");
        k(2'd0, 4'd6, 16'd6, 0, 0, 0, 0, "rp_d6");
        add(1'b1, 1'b1, 2'b00, 4'd9, 16'd0, 0, 0, 0, 0, "rst_wins");
        // dropped key in EXEC, ignored ops/equals, chaining
        k(2'd0, 4'd1, 16'd1, 0, 0, 0, 0, "dr_d1");
        k(2'd1, 4'd0, 16'd0, 0, 0, 0, 0, "dr_op");
        k(2'd0, 4'd2, 16'd2, 0, 0, 0, 0, "dr_d2");
        k(2'd1, 4'd1, 16'd2, 0, 0, 0, 0, "op_in_b");
        k(2'd2, 4'd0, 16'd2, 0, 0, 0, 1, "dr_exec");
        k(2'd0, 4'd7, 16'd3, 0, 1, 0, 0, "exec_drop");
        idle(16'd3, 0, 0, 0, 0, "dr_show");
        k(2'd1, 4'd0, 16'd0, 0, 0, 0, 0, "chain_ok");
        k(2'd0, 4'd4, 16'd4, 0, 0, 0, 0, "ch_d4");
        k(2'd2, 4'd0, 16'd4, 0, 0, 0, 1, "ch_exec");
        idle(16'd7, 0, 1, 0, 0, "ch_done");
        k(2'd0, 4'd5, 16'd5, 0, 0, 0, 0, "show_digit");
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "eq_clr");
        k(2'd2, 4'd0, 16'd0, 0, 0, 0, 0, "eq_in_a");
        k(2'd0, 4'd8, 16'd8, 0, 0, 0, 0, "eq_d8");
        k(2'd2, 4'd0, 16'd8, 0, 0, 0, 0, "eq_in_a2");
        k(2'd1, 4'd3, 16'd8, 0, 0, 1, 0, "op11");
        k(2'd0, 4'd1, 16'd8, 0, 0, 1, 0, "op11_hold");
        k(2'd3, 4'd0, 16'd0, 0, 0, 0, 0, "final_clr");

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].kv, vecs[i].kt, vecs[i].kval);
            tests++;
            if (DISP_VALUE !== vecs[i].disp || DISP_NEG !== vecs[i].neg || DONE !== vecs[i].done ||
                ERR !== vecs[i].err || BUSY !== vecs[i].busy) begin
                fails++;
                $display("FAIL %s (row %0d): got disp=%0d neg=%0b done=%0b err=%0b busy=%0b, expected disp=%0d neg=%0b done=%0b err=%0b busy=%0b",
                         vecs[i].name, i, DISP_VALUE, DISP_NEG, DONE, ERR, BUSY,
                         vecs[i].disp, vecs[i].neg, vecs[i].done, vecs[i].err, vecs[i].busy);
            end
        end

        // DONE latency: equals-cycle edge plus one EXEC edge.
        drive(1'b0, 1'b1, 2'd0, 4'd7);
        drive(1'b0, 1'b1, 2'd1, 4'd0);
        drive(1'b0, 1'b1, 2'd0, 4'd8);
        drive(1'b0, 1'b1, 2'd2, 4'd0);
        lat = 1;
        seen = 0;
        for (int unsigned c = 0; c < 8 && !seen; c++) begin
            drive(1'b0, 1'b0, 2'd0, 4'd0);
            lat++;
            if (DONE) seen = 1;
        end
        tests++;
        if (!seen || lat != 2 || DISP_VALUE !== 16'd15) begin
            fails++;
            $display("FAIL latency: got done_seen=%0b edges=%0d disp=%0d, expected done_seen=1 edges=2 disp=15",
                     seen, lat, DISP_VALUE);
        end

        // Random keys against the model.
        drive(1'b1, 1'b0, 2'd0, 4'd0);
        check_model("rand_reset");
        for (int unsigned c = 0; c < 3000; c++) begin
            bit          r_rst, r_kv;
            logic [1:0]  r_kt;
            logic [3:0]  r_val;
            int unsigned sel;
            r_rst = ($urandom % 256) == 0;
            r_kv  = $urandom % 2;
            sel   = $urandom % 20;
            r_kt  = (sel < 10) ? 2'd0 : (sel < 15) ? 2'd1 : (sel < 18) ? 2'd2 : 2'd3;
            if (r_kt == 2'd0)
                r_val = (($urandom % 8) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            else
                r_val = 4'($urandom % 16);
            drive(r_rst, r_kv, r_kt, r_val);
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter: MAX_DIGITS, default 3, maximum decimal digits accepted per operand.
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 KEY_VALID  input  1  one-cycle key strobe; KEY_TYPE/KEY_VAL are sampled only when high.
REQ-005 KEY_TYPE  input  2  00 digit, 01 operator, 10 equals, 11 clear.
REQ-006 KEY_VAL  input  4  digit 0-9 for a digit key; low 2 bits are the op code for an operator key (00 add, 01 sub, 10 mul).
REQ-007 ALU_A, ALU_B  output  8 each  operands driven to the ALU.
REQ-008 ALU_OP  output  2  op code driven to the ALU.
REQ-009 ALU_RESULT  input  16  combinational ALU result.
REQ-010 ALU_NEG  input  1  ALU negative flag.
REQ-011 DISP_VALUE  output  16  value to display.
REQ-012 DISP_NEG  output  1  display sign.
REQ-013 BUSY  output  1  high in EXEC.
REQ-014 DONE  output  1  one-cycle pulse when a result is captured.
REQ-015 ERR  output  1  high in ERROR.

Function
REQ-016 The FSM SHALL have the states ENTER_A, ENTER_B, EXEC, SHOW and ERROR; reset state is ENTER_A.
REQ-017 In ENTER_A/ENTER_B a digit key SHALL update the operand to operand*10+digit, computed at 12-bit width.
REQ-018 A digit key SHALL move the FSM to ERROR if the new value exceeds 255, the digit count would exceed MAX_DIGITS, or KEY_VAL > 9; the operand SHALL NOT change.
REQ-019 In ENTER_A an operator key with op 00/01/10 SHALL latch ALU_OP, clear B and its digit count, and move to ENTER_B.
REQ-020 An operator key with op 11, in any state, SHALL move to ERROR.
REQ-021 Equals in ENTER_A SHALL be ignored.
REQ-022 Equals in ENTER_B SHALL move to EXEC; an empty B (zero digits) counts as 0.
REQ-023 Operator keys in ENTER_B SHALL be ignored; only one operation is supported per expression.
REQ-024 EXEC SHALL last exactly one cycle with ALU_A/ALU_B/ALU_OP stable.
REQ-025 At the end of EXEC, DISP_VALUE <= ALU_RESULT and DISP_NEG <= ALU_NEG SHALL be registered, DONE SHALL pulse for one cycle, and the FSM SHALL go to SHOW.
REQ-026 Latency: with equals accepted at cycle N, DONE is high and DISP_VALUE is valid in cycle N+2.
REQ-027 Key strobes during EXEC SHALL be dropped.
REQ-028 In SHOW a digit key SHALL start a new expression: A <= digit, count 1, state ENTER_A.
REQ-029 In SHOW an operator key SHALL chain the calculation: A <= ALU_RESULT[7:0] when ALU_RESULT <= 255 and ALU_NEG = 0, otherwise ERROR; then continue as REQ-019.
REQ-030 Clear SHALL, in any state, zero A, B, the op code, both digit counts and the display, and move to ENTER_A in the next cycle.
REQ-031 Clear SHALL win over every other event in the same cycle.
REQ-032 ERROR SHALL ignore all keys except clear.
REQ-033 While the FSM is in ENTER_A, DISP_VALUE SHALL show the zero-extended A.
REQ-034 While the FSM is in ENTER_B, DISP_VALUE SHALL show the zero-extended B.
REQ-035 DISP_NEG SHALL be 0 outside SHOW.

Reset
REQ-036 RST high at any clock edge, including mid-EXEC, SHALL force ENTER_A and clear the operands, op code and counts.
REQ-037 Outputs after reset: DISP_VALUE=0, DISP_NEG=0, BUSY=0, DONE=0, ERR=0, ALU_A=0, ALU_B=0, ALU_OP=00.
REQ-038 RST SHALL take priority over KEY_VALID.

Structure
REQ-039 A shared package SHALL hold the state encoding, the KEY_TYPE codes, the op codes (add/sub/mul) and the constant 255 operand limit.
REQ-040 One sub-module, bcd_accum, SHALL perform the digit accumulation and overflow/digit-count checks; one instance is muxed to A or B.
REQ-041 The ALU SHALL be instantiated outside this block and connected through the ALU_* ports.

Verification
REQ-042 Keys 1,2,3,+,4,5,= -> DONE at N+2, DISP_VALUE=168, DISP_NEG=0.
REQ-043 Keys 5,-,9,= -> DISP_NEG=ALU_NEG=1 and DISP_VALUE=ALU_RESULT (0xFFFC).
REQ-044 Keys 2,5,5,*,2,5,5,= -> DISP_VALUE=65025; then *,2 -> ERROR, since 65025 > 255.
REQ-045 Keys 2,5,6 -> ERR=1 on the third digit; keys 1,2,3,4 -> ERR=1 on the fourth digit; clear -> ERR=0, DISP_VALUE=0.
REQ-046 RST pulsed in the EXEC cycle -> no DONE, all outputs at reset values; clear together with a digit -> clear wins.
REQ-047 Key strobe during EXEC is dropped; equals in ENTER_A is ignored; operator key with op 11 -> ERROR.
